// File: rtl/aula2910_qsys_mem_fill_check_if.sv
// Avalon-MM bus between the fill/check master and the s1 port of the on-chip RAM.
// The master modport drives the RAM; the slave modport returns read data.
interface aula2910_qsys_mem_fill_check_if #(
   parameter int ADDR_W = 14,
   parameter int DATA_W = 32
);
   logic [ADDR_W-1:0]   mem_address;
   logic [DATA_W/8-1:0] mem_byteenable;
   logic                mem_chipselect;
   logic                mem_write;
   logic [DATA_W-1:0]   mem_writedata;
   logic                mem_clken;
   logic [DATA_W-1:0]   mem_readdata;

   modport master (
      output mem_address, mem_byteenable, mem_chipselect, mem_write, mem_writedata, mem_clken,
      input  mem_readdata
   );

   modport slave (
      input  mem_address, mem_byteenable, mem_chipselect, mem_write, mem_writedata, mem_clken,
      output mem_readdata
   );
endinterface

// File: rtl/aula2910_qsys_mem_fill_check.sv
// Board self-test master: fills a RAM word range with a pattern, reads it back and counts mismatches.
// Optional macro MEMCHK_FIRST_ERR_EN adds capture of the first failing address and read data.
module aula2910_qsys_mem_fill_check #(
   parameter int ADDR_W = 14,
   parameter int DATA_W = 32,
   parameter int DEPTH  = 10240,
   parameter int ERR_W  = 16
) (
   input  logic                i_clk,
   input  logic                i_reset_n,
   input  logic                i_start,
   input  logic [ADDR_W-1:0]   i_base,
   input  logic [ADDR_W:0]     i_count,
   input  logic [DATA_W-1:0]   i_seed,
   input  logic                i_mode,
   output logic                o_busy,
   output logic                o_done,
   output logic [ERR_W-1:0]    o_error_count,
`ifdef MEMCHK_FIRST_ERR_EN
   output logic [ADDR_W-1:0]   o_first_err_addr,
   output logic [DATA_W-1:0]   o_first_err_data,
`endif
   aula2910_qsys_mem_fill_check_if.master m_mem
);

   localparam int             BE_W    = DATA_W / 8;
   localparam logic [ADDR_W:0] DEPTH_W = (ADDR_W + 1)'(DEPTH);

   typedef enum logic [2:0] {S_IDLE, S_FILL, S_VERIFY, S_DRAIN, S_DONE} state_t;

   state_t            r_state;
   logic [ADDR_W-1:0] r_base;
   logic [ADDR_W-1:0] r_addr;
   logic [ADDR_W-1:0] r_cmpAddr;
   logic [ADDR_W:0]   r_count;
   logic [ADDR_W:0]   r_idx;
   logic [DATA_W-1:0] r_seed;
   logic [DATA_W-1:0] r_wdata;
   logic [DATA_W-1:0] r_rdExp;
   logic [DATA_W-1:0] r_cmpExp;
   logic              r_mode;
   logic              r_cs;
   logic              r_we;
   logic              r_busy;
   logic              r_done;
   logic              r_cmpValid;
   logic [ERR_W-1:0]  r_err;
`ifdef MEMCHK_FIRST_ERR_EN
   logic [ADDR_W-1:0] r_firstAddr;
   logic [DATA_W-1:0] r_firstData;
`endif

   logic [ADDR_W:0]   w_baseWide;
   logic [ADDR_W-1:0] w_baseIn;
   logic [ADDR_W:0]   w_countIn;
   logic [ADDR_W-1:0] w_addrNext;
   logic [DATA_W-1:0] w_pattern;
   logic              w_mismatch;

   // The base port is narrower than twice DEPTH, so one conditional subtract reduces it.
   assign w_baseWide = {1'b0, i_base};
   assign w_baseIn   = (w_baseWide >= DEPTH_W) ? ADDR_W'(w_baseWide - DEPTH_W) : i_base;
   assign w_countIn  = (i_count > DEPTH_W) ? DEPTH_W : i_count;
   assign w_addrNext = ({1'b0, r_addr} == DEPTH_W - 1'b1) ? '0 : r_addr + ADDR_W'(1);
   assign w_pattern  = r_mode ? r_seed + DATA_W'(r_idx) : r_seed;
   assign w_mismatch = r_cmpValid && (m_mem.mem_readdata != r_cmpExp);

   assign m_mem.mem_address    = r_addr;
   assign m_mem.mem_byteenable = {BE_W{r_cs}};
   assign m_mem.mem_chipselect = r_cs;
   assign m_mem.mem_write      = r_we;
   assign m_mem.mem_writedata  = r_wdata;
   assign m_mem.mem_clken      = r_busy;

   assign o_busy        = r_busy;
   assign o_done        = r_done;
   assign o_error_count = r_err;
`ifdef MEMCHK_FIRST_ERR_EN
   assign o_first_err_addr = r_firstAddr;
   assign o_first_err_data = r_firstData;
`endif

   // r_idx always holds the index of the next access to issue; expected read data
   // trails the issued read by one cycle to line up with the RAM's registered address.
   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         r_state    <= S_IDLE;
         r_base     <= '0;
         r_addr     <= '0;
         r_cmpAddr  <= '0;
         r_count    <= '0;
         r_idx      <= '0;
         r_seed     <= '0;
         r_wdata    <= '0;
         r_rdExp    <= '0;
         r_cmpExp   <= '0;
         r_mode     <= 1'b0;
         r_cs       <= 1'b0;
         r_we       <= 1'b0;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
         r_cmpValid <= 1'b0;
         r_err      <= '0;
`ifdef MEMCHK_FIRST_ERR_EN
         r_firstAddr <= '0;
         r_firstData <= '0;
`endif
      end else begin
         r_done     <= 1'b0;
         r_cmpValid <= r_cs && !r_we;
         r_cmpExp   <= r_rdExp;
         r_cmpAddr  <= r_addr;

         if (w_mismatch) begin
            if (r_err != '1) begin
               r_err <= r_err + ERR_W'(1);
            end
`ifdef MEMCHK_FIRST_ERR_EN
            if (r_err == '0) begin
               r_firstAddr <= r_cmpAddr;
               r_firstData <= m_mem.mem_readdata;
            end
`endif
         end

         case (r_state)
            S_IDLE: begin
               if (i_start) begin
                  r_err <= '0;
`ifdef MEMCHK_FIRST_ERR_EN
                  r_firstAddr <= '0;
                  r_firstData <= '0;
`endif
                  if (i_count == '0) begin
                     r_done <= 1'b1;
                  end else begin
                     r_state <= S_FILL;
                     r_base  <= w_baseIn;
                     r_count <= w_countIn;
                     r_seed  <= i_seed;
                     r_mode  <= i_mode;
                     r_busy  <= 1'b1;
                     r_cs    <= 1'b1;
                     r_we    <= 1'b1;
                     r_addr  <= w_baseIn;
                     r_wdata <= i_seed;
                     r_idx   <= (ADDR_W + 1)'(1);
                  end
               end
            end
            S_FILL: begin
               if (r_idx == r_count) begin
                  r_state <= S_VERIFY;
                  r_we    <= 1'b0;
                  r_addr  <= r_base;
                  r_wdata <= '0;
                  r_rdExp <= r_seed;
                  r_idx   <= (ADDR_W + 1)'(1);
               end else begin
                  r_addr  <= w_addrNext;
                  r_wdata <= w_pattern;
                  r_idx   <= r_idx + 1'b1;
               end
            end
            S_VERIFY: begin
               if (r_idx == r_count) begin
                  r_state <= S_DRAIN;
                  r_cs    <= 1'b0;
                  r_addr  <= '0;
                  r_rdExp <= '0;
               end else begin
                  r_addr  <= w_addrNext;
                  r_rdExp <= w_pattern;
                  r_idx   <= r_idx + 1'b1;
               end
            end
            S_DRAIN: begin
               r_state <= S_DONE;
               r_busy  <= 1'b0;
               r_done  <= 1'b1;
               r_idx   <= '0;
            end
            S_DONE: begin
               r_state <= S_IDLE;
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: doc/aula2910_qsys_mem_fill_check.md
Name: aula2910_qsys_mem_fill_check

Overview:
- Avalon-MM master stage that sits directly upstream of the 32-bit single-port on-chip RAM and drives its s1 port.
- On a start pulse it fills a word range with a generated pattern, then reads the range back and compares each word.
- Reports busy, done, error count and first failing address to the control logic, for the board self-test after configuration.
- RAM read latency is fixed at 1 clock: address is registered in the RAM, q is unregistered.

Parameters:
ADDR_W, 14, word address width of the RAM port
DATA_W, 32, data width (byteenable width = DATA_W/8)
DEPTH, 10240, number of words; addresses wrap DEPTH-1 -> 0
ERR_W, 16, error counter width (saturating)

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
start  in  1  one-cycle start pulse; ignored while busy
base  in  ADDR_W  first word address, sampled on start
count  in  ADDR_W+1  number of words, sampled on start
seed  in  DATA_W  pattern seed, sampled on start
mode  in  1  0 = constant seed; 1 = seed + word index (mod 2^DATA_W)
busy  out  1  high while an operation is in progress
done  out  1  one-cycle pulse at completion
error_count  out  ERR_W  mismatches in the last run
mem_address  out  ADDR_W  to RAM address
mem_byteenable  out  DATA_W/8  to RAM byteenable; all ones when chipselect high
mem_chipselect  out  1  to RAM chipselect
mem_write  out  1  to RAM write
mem_writedata  out  DATA_W  to RAM writedata
mem_clken  out  1  to RAM clken; high while busy
mem_readdata  in  DATA_W  from RAM readdata

Behaviour:
- Reset (async assert, sync release): state IDLE; all outputs 0; error_count 0.
- IDLE:
  - start && count!=0: latch base, count, seed and mode; clear error_count; go to FILL; busy=1 from the next cycle.
  - start && count==0: done pulses on the next cycle; busy stays 0; error_count is cleared to 0.
- FILL:
  - One write per cycle: chipselect=1, write=1, address=base+i (wrapping at DEPTH), writedata=pattern(i).
  - After count writes, go to VERIFY.
- VERIFY:
  - One read per cycle: chipselect=1, write=0, address=base+i.
  - The expected value is delayed one cycle and compared with mem_readdata on the following cycle.
  - After count issues, go to DRAIN.
- DRAIN:
  - No access; the last compare occurs in this cycle. Go to DONE.
- DONE:
  - done=1 for exactly one cycle; busy=0 in this cycle; return to IDLE.
- Timing: start at cycle 0 -> done at cycle 2*count+2.
- Pattern: i counts from 0 to count-1. Mode 1 addition is modulo 2^DATA_W.
- error_count saturates at 2^ERR_W-1. It holds its value until the next accepted start.
- Address wrap: base+i >= DEPTH uses base+i-DEPTH. base >= DEPTH is reduced modulo DEPTH at latch time.
- count > DEPTH is clamped to DEPTH.
- start while busy is ignored and has no effect on the latched registers.
- reset_n asserted mid-operation aborts immediately, leaving RAM contents partially written. No done pulse is generated.

Optional Feature:
- Macro: MEMCHK_FIRST_ERR_EN.
- Defined: adds outputs first_err_addr (ADDR_W) and first_err_data (DATA_W).
  - These capture the address and mem_readdata of the first mismatch of a run.
  - Both are cleared to 0 on an accepted start and on reset.
- Undefined: these ports do not exist; other behaviour is identical.

Test Plan:
- base=0, count=16, seed=0xA5A5A5A5, mode=0, clean RAM model -> 16 writes then 16 reads; done at cycle 34; error_count=0.
- base=100, count=8, seed=0x1000, mode=1 -> writedata 0x1000..0x1007 at addresses 100..107; error_count=0.
- base=10238, count=4 -> addresses 10238, 10239, 0, 1 in both phases; no out-of-range address.
- Inject corruption at word index 3 (flip bit 0 in the RAM model before VERIFY); base=20, count=8 -> error_count=1; with MEMCHK_FIRST_ERR_EN, first_err_addr=23.
- count=0 -> done one cycle after start; busy never high; no chipselect. Second start during FILL -> ignored; the run finishes unchanged.
- Deassert reset_n mid-FILL at i=5 -> busy=0 and chipselect=0 immediately; no done pulse; a new start then runs normally.
